// File: rtl/enokida_data_mem_responder.sv
// rtl/enokida_data_mem_responder.sv - memory-side responder for the RI5CY-style data port of the enokida caches
//
// Accepts req/addr/we/be/wdata, grants combinationally, and answers every
// granted transaction with one rvalid cycle a fixed READ_LATENCY later,
// backed by a word-organised internal RAM. Also provides optional periodic
// grant stalls and granted read/write counters.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   data_req_i        request
//   data_addr_i       byte address; word index = addr[2 +: log2(MEM_DEPTH)]
//   data_we_i         1 = write, 0 = read
//   data_be_i         byte enables for writes
//   data_wdata_i      write data
//   data_gnt_o        combinational grant
//   data_rvalid_o     one response cycle per granted transaction
//   data_rdata_o      read data (0 for write responses), held while rvalid=0
//   read_count_o      granted reads since reset (wrapping)
//   write_count_o     granted writes since reset (wrapping)

module enokida_data_mem_responder #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH       = 4096,
  parameter int READ_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STALL_EVERY     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [31:0]             read_count_o,
  output logic [31:0]             write_count_o
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam int STALL_W = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  unused_addr;

  // Byte offset and bits above the RAM window do not select a word.
  assign idx         = data_addr_i[2 +: IDX_W];
  assign unused_addr = ^data_addr_i;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   last_rdata;
  logic [OUT_W-1:0]        outstanding;
  logic                    stall_now;
  logic                    room;

  // A response leaving this cycle frees its slot for a grant in the same cycle.
  assign room = (outstanding - OUT_W'(data_rvalid_o)) < OUT_W'(MAX_OUTSTANDING);

  assign data_gnt_o    = data_req_i & ~rst & room & ~stall_now;
  assign data_rvalid_o = pipe_valid[READ_LATENCY-1];
  assign data_rdata_o  = data_rvalid_o ? pipe_data[READ_LATENCY-1] : last_rdata;

  generate
    if (STALL_EVERY > 0) begin : g_stall
      logic [STALL_W-1:0] stall_cnt;

      // Counts request-high cycles only; the last count of each period withholds gnt.
      assign stall_now = (stall_cnt == STALL_W'(STALL_EVERY - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          stall_cnt <= '0;
        end else if (data_req_i) begin
          stall_cnt <= stall_now ? '0 : stall_cnt + 1'b1;
        end
      end
    end else begin : g_no_stall
      assign stall_now = 1'b0;
    end
  endgenerate

  // RAM write at the edge closing the gnt cycle; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (data_gnt_o && data_we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (data_be_i[b]) begin
          mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures the RAM word in the gnt cycle, so a
  // read right after a write to the same word already sees the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      pipe_valid[0] <= data_gnt_o;
      pipe_data[0]  <= data_we_i ? '0 : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rdata    <= '0;
      outstanding   <= '0;
      read_count_o  <= '0;
      write_count_o <= '0;
    end else begin
      if (data_rvalid_o) begin
        last_rdata <= pipe_data[READ_LATENCY-1];
      end
      outstanding <= outstanding + OUT_W'(data_gnt_o) - OUT_W'(data_rvalid_o);
      if (data_gnt_o) begin
        if (data_we_i) begin
          write_count_o <= write_count_o + 32'd1;
        end else begin
          read_count_o <= read_count_o + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_enokida_data_mem_responder.sv
// tb/tb_enokida_data_mem_responder.sv - self-checking bench for enokida_data_mem_responder

module tb_enokida_data_mem_responder;

  localparam int LAT = 2;
  localparam int MAXO [3] = '{2, 1, 2};
  localparam int STL  [3] = '{0, 0, 3};

  logic        clk;
  logic        rst;
  logic        req  [3];
  logic [15:0] addr [3];
  logic        we   [3];
  logic [3:0]  be   [3];
  logic [31:0] wd   [3];
  logic        gnt  [3];
  logic        rv   [3];
  logic [31:0] rd   [3];
  logic [31:0] rc   [3];
  logic [31:0] wc   [3];

  enokida_data_mem_responder u_dut (
    .clk(clk), .rst(rst), .data_req_i(req[0]), .data_addr_i(addr[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_wdata_i(wd[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rv[0]),
    .data_rdata_o(rd[0]), .read_count_o(rc[0]), .write_count_o(wc[0])
  );

  enokida_data_mem_responder #(.MAX_OUTSTANDING(1)) u_mo1 (
    .clk(clk), .rst(rst), .data_req_i(req[1]), .data_addr_i(addr[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_wdata_i(wd[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rv[1]),
    .data_rdata_o(rd[1]), .read_count_o(rc[1]), .write_count_o(wc[1])
  );

  enokida_data_mem_responder #(.STALL_EVERY(3)) u_stl (
    .clk(clk), .rst(rst), .data_req_i(req[2]), .data_addr_i(addr[2]), .data_we_i(we[2]),
    .data_be_i(be[2]), .data_wdata_i(wd[2]), .data_gnt_o(gnt[2]), .data_rvalid_o(rv[2]),
    .data_rdata_o(rd[2]), .read_count_o(rc[2]), .write_count_o(wc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RAM image, queue of expected responses, simple counts.
  logic [31:0] mm [3][4096];
  int unsigned qdue [3][$];
  logic [31:0] qdat [3][$];
  int          cyc  [3];
  int          rq   [3];
  logic [31:0] rcnt [3];
  logic [31:0] wcnt [3];
  logic [31:0] lastd [3];
  logic [31:0] last_resp [3];
  logic        obs_gnt [3];
  int          tests;
  int          fails;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int s);
    logic       erv;
    logic       eg;
    logic       st;
    int         pend;
    logic [11:0] wi;
    pend = qdue[s].size();
    erv  = (pend > 0) && (qdue[s][0] == cyc[s]);
    st   = (STL[s] > 0) && ((rq[s] % STL[s]) == STL[s] - 1);
    eg   = req[s] && ((pend - (erv ? 1 : 0)) < MAXO[s]) && !st;
    obs_gnt[s] = gnt[s];
    chk(32'(gnt[s]), 32'(eg), $sformatf("gnt[%0d]", s));
    chk(32'(rv[s]), 32'(erv), $sformatf("rvalid[%0d]", s));
    if (erv) begin
      chk(rd[s], qdat[s][0], $sformatf("rdata[%0d]", s));
      lastd[s]     = qdat[s][0];
      last_resp[s] = rd[s];
      qdue[s].delete(0);
      qdat[s].delete(0);
    end else begin
      chk(rd[s], lastd[s], $sformatf("rdata_hold[%0d]", s));
    end
    chk(rc[s], rcnt[s], $sformatf("read_count[%0d]", s));
    chk(wc[s], wcnt[s], $sformatf("write_count[%0d]", s));
    if (eg) begin
      wi = addr[s][13:2];
      qdue[s].push_back(cyc[s] + LAT);
      if (we[s]) begin
        qdat[s].push_back(32'h0);
        for (int b = 0; b < 4; b++)
          if (be[s][b]) mm[s][wi][8*b +: 8] = wd[s][8*b +: 8];
        wcnt[s]++;
      end else begin
        qdat[s].push_back(mm[s][wi]);
        rcnt[s]++;
      end
    end
    if (req[s]) rq[s]++;
    cyc[s]++;
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int s = 0; s < 3; s++) tick(s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) chk(32'(gnt[s]), 32'h0, $sformatf("gnt_in_reset[%0d]", s));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      qdue[s].delete();
      qdat[s].delete();
      cyc[s]   = 0;
      rq[s]    = 0;
      rcnt[s]  = 0;
      wcnt[s]  = 0;
      lastd[s] = 32'h0;
    end
  endtask

  task automatic send(input int s, input logic w, input logic [15:0] a, input logic [3:0] b,
                      input logic [31:0] d);
    int k;
    req[s] = 1'b1; we[s] = w; addr[s] = a; be[s] = b; wd[s] = d;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!obs_gnt[s] && k < 20);
    if (!obs_gnt[s]) chk(32'h0, 32'h1, "send_timeout");
  endtask

  task automatic idle(input int s, input int n);
    req[s] = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    logic [8:0]  gpat;
    int          k;
    int          c0;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    for (int s = 0; s < 3; s++) begin
      req[s] = 1'b0; addr[s] = '0; we[s] = 1'b0; be[s] = '0; wd[s] = '0;
      last_resp[s] = '0; obs_gnt[s] = 1'b0;
      for (int i = 0; i < 4096; i++) mm[s][i] = 32'h0;
    end

    do_reset();
    idle(0, 1);

    // Full write then read of one word.
    send(0, 1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
    send(0, 1'b0, 16'h0010, 4'hF, 32'h0);
    idle(0, 4);
    chk(last_resp[0], 32'hDEADBEEF, "t1_read");
    chk(rc[0], 32'd1, "t1_rc");
    chk(wc[0], 32'd1, "t1_wc");

    // Partial byte-enable merge.
    send(0, 1'b1, 16'h0020, 4'hF, 32'h11223344);
    send(0, 1'b1, 16'h0020, 4'b0101, 32'hAABBCCDD);
    send(0, 1'b0, 16'h0020, 4'hF, 32'h0);
    idle(0, 4);
    chk(last_resp[0], 32'h11BB33DD, "t2_merge");

    // Six back-to-back reads.
    do_reset();
    c0 = cyc[0];
    for (int i = 0; i < 6; i++) send(0, 1'b0, 16'h0010 + 16'(4 * (i % 2)), 4'hF, 32'h0);
    chk(32'(cyc[0] - c0), 32'd6, "t3_b2b_cycles");
    idle(0, 4);
    chk(rc[0], 32'd6, "t3_rc");

    // Single outstanding slot: grant every other cycle.
    send(1, 1'b1, 16'h0010, 4'hF, 32'h5A5A1234);
    idle(1, 4);
    gpat = '0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0010; be[1] = 4'hF;
    for (int i = 0; i < 8; i++) begin
      cycle();
      gpat[i] = obs_gnt[1];
    end
    idle(1, 4);
    chk(32'(gpat[7:0]), 32'h55, "t4_gnt_pattern");

    // Stall every third request cycle; held address must still be served.
    for (int i = 0; i < 6; i++) send(2, 1'b1, 16'h0010 + 16'(4 * i), 4'hF, 32'hC0DE0000 + 32'(i));
    idle(2, 4);
    do_reset();
    gpat = '0;
    k = 0;
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF;
    for (int i = 0; i < 9; i++) begin
      addr[2] = 16'h0010 + 16'(4 * (k % 6));
      cycle();
      gpat[i] = obs_gnt[2];
      if (obs_gnt[2]) k++;
    end
    idle(2, 4);
    chk(32'(gpat), 32'h0DB, "t5_gnt_pattern");
    chk(32'(k), 32'd6, "t5_grants");
    chk(last_resp[2], 32'hC0DE0005, "t5_last_read");

    // Reset with responses in flight.
    do_reset();
    send(0, 1'b1, 16'h0040, 4'hF, 32'hCAFEF00D);
    send(0, 1'b0, 16'h0010, 4'hF, 32'h0);
    do_reset();
    idle(0, 4);
    chk(rc[0], 32'd0, "t6_rc");
    chk(wc[0], 32'd0, "t6_wc");
    send(0, 1'b0, 16'h0040, 4'hF, 32'h0);
    idle(0, 4);
    chk(last_resp[0], 32'hCAFEF00D, "t6_retained");

    // Randomized traffic on every instance over a 16-word window, with
    // random don't-care address bits.
    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < 16; w++)
        send(s, 1'b1, 16'h0100 + 16'(4 * w), 4'hF, $urandom);
      for (int n = 0; n < 120; n++) begin
        logic [15:0] a;
        if ($urandom_range(0, 3) == 0) idle(s, $urandom_range(1, 3));
        a = 16'h0100 + 16'(4 * $urandom_range(0, 15));
        a[15:14] = 2'($urandom);
        a[1:0]   = 2'($urandom);
        send(s, 1'($urandom), a, 4'($urandom), $urandom);
      end
      idle(s, 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
